// File: rtl/lcd_cmd_seq_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, FSM states
// and the saturating issue-counter helper.
package lcd_cmd_seq_pkg;

  localparam int unsigned CMD_W    = 3;
  localparam int unsigned ISSUED_W = 7;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRTBK = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DN    = 3'd2,
    CMD_LF    = 3'd3,
    CMD_RT    = 3'd4,
    CMD_AVG   = 3'd5,
    CMD_MRR_X = 3'd6,
    CMD_MRR_Y = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_FINISH
  } state_e;

  // Increment that sticks at the all-ones value.
  function automatic logic [ISSUED_W-1:0] sat_inc(input logic [ISSUED_W-1:0] v);
    return (v == '1) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Command handshake between the sequencer (master) and the LCD controller (slave).
interface lcd_cmd_seq_if;
  import lcd_cmd_seq_pkg::*;

  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;

  modport master (output cmd, output cmd_valid, input busy, input done);
  modport slave  (input cmd, input cmd_valid, output busy, output done);

endinterface

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x 3-bit synchronous FIFO. A push into a full FIFO is accepted when a
// pop happens in the same cycle; push_ok reports whether the push was taken.
module lcd_cmd_fifo
  import lcd_cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic             push_ok,
  output logic             full,
  output logic             empty,
  output logic [CMD_W-1:0] head
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic             do_pop;

  // Status, handshake qualification and next pointer/count values.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    do_pop   = pop & ~empty;
    push_ok  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands and replays them to the LCD
// controller one per handshake while it is idle, then waits for write-back
// completion after WRTBK has been issued.
module lcd_cmd_seq
  import lcd_cmd_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_wr,
  input  logic [CMD_W-1:0]    host_cmd,
  output logic                host_full,
  input  logic                start,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                ovf,
  output logic [ISSUED_W-1:0] issued,
  lcd_cmd_seq_if.master       lcd
);

  localparam logic [2:0] GAP_INIT = 3'(GAP);

  state_e              state_q, state_d;
  logic [2:0]          gap_q, gap_d;
  logic [ISSUED_W-1:0] issued_q, issued_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                seq_busy_q, seq_busy_d;
  logic                seq_done_q, seq_done_d;
  logic                ovf_q, ovf_d;
  logic                wrtbk_seen_q, wrtbk_seen_d;

  logic                fifo_push, fifo_pop, fifo_push_ok;
  logic                fifo_full, fifo_empty;
  logic [CMD_W-1:0]    fifo_head;

  // Once WRTBK is queued nothing may follow it; FINISH is only reachable
  // after a queued WRTBK, so this gate also blocks pushes in FINISH.
  always_comb begin
    fifo_push = host_wr & ~wrtbk_seen_q & (state_q != ST_FINISH);
    fifo_pop  = (state_q == ST_ISSUE);
  end

  lcd_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (host_cmd),
    .push_ok(fifo_push_ok),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Next-state, gap/issue counters, command register and sticky flags.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    issued_d     = issued_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    seq_busy_d   = seq_busy_q;
    seq_done_d   = seq_done_q;
    ovf_d        = ovf_q;
    wrtbk_seen_d = wrtbk_seen_q;

    if (host_wr && !fifo_push_ok)                   ovf_d        = 1'b1;
    if (fifo_push_ok && (host_cmd == CMD_WRTBK))    wrtbk_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT_RDY;
          seq_busy_d = 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        if (!lcd.busy && !fifo_empty && (gap_q == '0)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_d       = fifo_head;
        cmd_valid_d = 1'b1;
        issued_d    = sat_inc(issued_q);
        if (fifo_head == CMD_WRTBK) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_RDY;
          gap_d   = GAP_INIT;
        end
      end
      ST_WAIT_DONE: begin
        if (lcd.done) begin
          state_d    = ST_FINISH;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_FINISH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gap_q        <= '0;
      issued_q     <= '0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      seq_busy_q   <= 1'b0;
      seq_done_q   <= 1'b0;
      ovf_q        <= 1'b0;
      wrtbk_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      issued_q     <= issued_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      seq_busy_q   <= seq_busy_d;
      seq_done_q   <= seq_done_d;
      ovf_q        <= ovf_d;
      wrtbk_seen_q <= wrtbk_seen_d;
    end
  end

  always_comb begin
    host_full     = fifo_full;
    seq_busy      = seq_busy_q;
    seq_done      = seq_done_q;
    ovf           = ovf_q;
    issued        = issued_q;
    lcd.cmd       = cmd_q;
    lcd.cmd_valid = cmd_valid_q;
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq (DEPTH=16, GAP=1). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_lcd_cmd_seq;
  import lcd_cmd_seq_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       host_wr = 1'b0;
  logic [2:0] host_cmd = 3'd0;
  logic       host_full;
  logic       start = 1'b0;
  logic       seq_busy, seq_done, ovf;
  logic [6:0] issued;

  int vec_cnt = 0;
  int err_cnt = 0;

  lcd_cmd_seq_if lcd();

  lcd_cmd_seq #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .host_wr  (host_wr),
    .host_cmd (host_cmd),
    .host_full(host_full),
    .start    (start),
    .seq_busy (seq_busy),
    .seq_done (seq_done),
    .ovf      (ovf),
    .issued   (issued),
    .lcd      (lcd)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    host_wr = 1'b0; host_cmd = 3'd0; start = 1'b0; lcd.busy = 1'b0; lcd.done = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push_cmd(input logic [2:0] c);
    host_wr = 1'b1; host_cmd = c;
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_done();
    lcd.done = 1'b1;
    @(negedge clk);
    lcd.done = 1'b0;
  endtask

  // Advance until cmd_valid is seen or the budget runs out.
  task automatic wait_valid(input int budget, output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (lcd.cmd_valid === 1'b1) begin
        got = 1'b1; cyc = i;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (lcd.cmd_valid !== 1'b0) hits++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({lcd.cmd, lcd.cmd_valid, seq_busy, seq_done, ovf, issued, host_full} !== 15'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs got cmd=%0d v=%0d busy=%0d done=%0d ovf=%0d issued=%0d full=%0d exp all 0",
               lcd.cmd, lcd.cmd_valid, seq_busy, seq_done, ovf, issued, host_full);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_seq();
    bit got; int cyc; int hits;
    logic [2:0] exp_cmd [4];
    exp_cmd[0] = CMD_RT; exp_cmd[1] = CMD_DN; exp_cmd[2] = CMD_AVG; exp_cmd[3] = CMD_WRTBK;
    apply_reset();
    for (int i = 0; i < 4; i++) push_cmd(exp_cmd[i]);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_valid(20, got, cyc);
      vec_cnt++;
      if (!got || cyc != ((i == 0) ? 2 : 3) || lcd.cmd !== exp_cmd[i]) begin
        err_cnt++;
        $display("FAIL basic_pulse%0d got valid=%0d after %0d cyc cmd=%0d exp after %0d cyc cmd=%0d",
                 i, got, cyc, lcd.cmd, (i == 0) ? 2 : 3, exp_cmd[i]);
      end
    end
    vec_cnt++;
    if (issued !== 7'd4 || ovf !== 1'b0) begin
      err_cnt++; $display("FAIL basic_issued got issued=%0d ovf=%0d exp 4 0", issued, ovf);
    end
    count_valid(70, hits);
    vec_cnt++;
    if (hits != 0 || seq_done !== 1'b0 || seq_busy !== 1'b1 || lcd.cmd !== 3'd0) begin
      err_cnt++;
      $display("FAIL basic_wait_done got hits=%0d done=%0d busy=%0d cmd=%0d exp 0 0 1 0", hits, seq_done, seq_busy, lcd.cmd);
    end
    pulse_done();
    vec_cnt++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      err_cnt++; $display("FAIL basic_finish got done=%0d busy=%0d exp 1 0", seq_done, seq_busy);
    end
    push_cmd(CMD_UP);
    pulse_start();
    count_valid(10, hits);
    vec_cnt++;
    if (ovf !== 1'b1 || hits != 0 || seq_done !== 1'b1 || issued !== 7'd4) begin
      err_cnt++;
      $display("FAIL finish_terminal got ovf=%0d hits=%0d done=%0d issued=%0d exp 1 0 1 4", ovf, hits, seq_done, issued);
    end
  endtask

  task automatic test_busy_hold();
    bit got; int cyc; int hits;
    apply_reset();
    push_cmd(CMD_UP); push_cmd(CMD_WRTBK);
    lcd.busy = 1'b1;
    pulse_start();
    count_valid(65, hits);
    vec_cnt++;
    if (hits != 0 || issued !== 7'd0 || seq_busy !== 1'b1) begin
      err_cnt++; $display("FAIL busy_hold got hits=%0d issued=%0d busy=%0d exp 0 0 1", hits, issued, seq_busy);
    end
    lcd.busy = 1'b0;
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== CMD_UP) begin
      err_cnt++; $display("FAIL busy_release got valid=%0d cyc=%0d cmd=%0d exp 1 2 %0d", got, cyc, lcd.cmd, CMD_UP);
    end
    // busy rises during the gap after the first issue
    lcd.busy = 1'b1;
    count_valid(5, hits);
    lcd.busy = 1'b0;
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (hits != 0 || !got || cyc != 2 || lcd.cmd !== CMD_WRTBK) begin
      err_cnt++;
      $display("FAIL busy_in_gap got hits=%0d valid=%0d cyc=%0d cmd=%0d exp 0 1 2 0", hits, got, cyc, lcd.cmd);
    end
    pulse_done();
    vec_cnt++;
    if (seq_done !== 1'b1 || issued !== 7'd2) begin
      err_cnt++; $display("FAIL busy_finish got done=%0d issued=%0d exp 1 2", seq_done, issued);
    end
  endtask

  task automatic test_fifo_full();
    bit got; int cyc;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      push_cmd(3'((i % 7) + 1));
      if (i == 14) begin
        vec_cnt++;
        if (host_full !== 1'b0) begin err_cnt++; $display("FAIL full_at15 got %0d exp 0", host_full); end
      end
    end
    vec_cnt++;
    if (host_full !== 1'b1 || ovf !== 1'b0) begin
      err_cnt++; $display("FAIL full_at16 got full=%0d ovf=%0d exp 1 0", host_full, ovf);
    end
    push_cmd(3'd2);
    vec_cnt++;
    if (host_full !== 1'b1 || ovf !== 1'b1) begin
      err_cnt++; $display("FAIL full_drop17 got full=%0d ovf=%0d exp 1 1", host_full, ovf);
    end
    // WRTBK offered every cycle: only the push coinciding with the first pop fits
    host_wr = 1'b1; host_cmd = CMD_WRTBK;
    pulse_start();
    wait_valid(10, got, cyc);
    host_wr = 1'b0;
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== 3'd1 || host_full !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_push_pop got valid=%0d cyc=%0d cmd=%0d full=%0d exp 1 2 1 1", got, cyc, lcd.cmd, host_full);
    end
    for (int i = 1; i < 17; i++) begin
      logic [2:0] e;
      e = (i == 16) ? 3'd0 : 3'((i % 7) + 1);
      wait_valid(10, got, cyc);
      vec_cnt++;
      if (!got || cyc != 3 || lcd.cmd !== e) begin
        err_cnt++; $display("FAIL full_drain%0d got valid=%0d cyc=%0d cmd=%0d exp 1 3 %0d", i, got, cyc, lcd.cmd, e);
      end
    end
    vec_cnt++;
    if (issued !== 7'd17 || host_full !== 1'b0 || seq_done !== 1'b0) begin
      err_cnt++; $display("FAIL full_end got issued=%0d full=%0d done=%0d exp 17 0 0", issued, host_full, seq_done);
    end
  endtask

  task automatic test_empty_start();
    bit got; int cyc; int hits;
    apply_reset();
    pulse_start();
    count_valid(10, hits);
    vec_cnt++;
    if (hits != 0 || seq_busy !== 1'b1) begin
      err_cnt++; $display("FAIL empty_wait got hits=%0d busy=%0d exp 0 1", hits, seq_busy);
    end
    push_cmd(CMD_UP);
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== CMD_UP || issued !== 7'd1) begin
      err_cnt++;
      $display("FAIL empty_late_push got valid=%0d cyc=%0d cmd=%0d issued=%0d exp 1 2 1 1", got, cyc, lcd.cmd, issued);
    end
  endtask

  task automatic test_reset_mid();
    bit got; int cyc; int hits;
    apply_reset();
    push_cmd(CMD_UP); push_cmd(CMD_DN); push_cmd(CMD_LF); push_cmd(CMD_RT); push_cmd(CMD_AVG);
    pulse_start();
    wait_valid(10, got, cyc);
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || lcd.cmd !== CMD_DN || issued !== 7'd2) begin
      err_cnt++; $display("FAIL mid_second got valid=%0d cmd=%0d issued=%0d exp 1 2 2", got, lcd.cmd, issued);
    end
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({lcd.cmd, lcd.cmd_valid, seq_busy, seq_done, ovf, issued, host_full} !== 15'd0) begin
      err_cnt++;
      $display("FAIL mid_reset got cmd=%0d v=%0d busy=%0d done=%0d ovf=%0d issued=%0d exp all 0",
               lcd.cmd, lcd.cmd_valid, seq_busy, seq_done, ovf, issued);
    end
    @(negedge clk);
    reset = 1'b1;
    pulse_start();
    count_valid(10, hits);
    vec_cnt++;
    if (hits != 0 || issued !== 7'd0 || seq_busy !== 1'b1) begin
      err_cnt++; $display("FAIL mid_restart got hits=%0d issued=%0d busy=%0d exp 0 0 1", hits, issued, seq_busy);
    end
    push_cmd(CMD_LF);
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== CMD_LF) begin
      err_cnt++; $display("FAIL mid_new_push got valid=%0d cyc=%0d cmd=%0d exp 1 2 3", got, cyc, lcd.cmd);
    end
  endtask

  task automatic test_early_done();
    bit got; int cyc;
    apply_reset();
    push_cmd(CMD_UP); push_cmd(CMD_WRTBK);
    pulse_done();
    pulse_start();
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== CMD_UP || seq_done !== 1'b0) begin
      err_cnt++; $display("FAIL early_first got valid=%0d cyc=%0d cmd=%0d done=%0d exp 1 2 1 0", got, cyc, lcd.cmd, seq_done);
    end
    pulse_done();
    wait_valid(10, got, cyc);
    vec_cnt++;
    if (!got || cyc != 2 || lcd.cmd !== CMD_WRTBK || seq_done !== 1'b0) begin
      err_cnt++; $display("FAIL early_wrtbk got valid=%0d cyc=%0d cmd=%0d done=%0d exp 1 2 0 0", got, cyc, lcd.cmd, seq_done);
    end
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (seq_done !== 1'b0 || seq_busy !== 1'b1) begin
      err_cnt++; $display("FAIL early_hold got done=%0d busy=%0d exp 0 1", seq_done, seq_busy);
    end
    pulse_done();
    vec_cnt++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      err_cnt++; $display("FAIL early_finish got done=%0d busy=%0d exp 1 0", seq_done, seq_busy);
    end
  endtask

  initial begin
    lcd.busy = 1'b0;
    lcd.done = 1'b0;
    test_reset();
    test_basic_seq();
    test_busy_hold();
    test_fifo_full();
    test_empty_start();
    test_reset_mid();
    test_early_done();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
